manchester_frame_decoder: RTL and testbench

Bit/frame recovery stage directly downstream of `delayBlock` in the Manchester decoder. It samples the synchronised Manchester line on each `delayPulse`, which arrives in the second half of every bit cell. It hunts for a sync word, reads a length byte, then assembles and hands off payload bytes over a valid/ready interface. Frame start, end and error events are flagged for the LED control processor.

---
 rtl/manchester_frame_decoder.sv | 138 +++++++++++++
 tb/tb_manchester_frame_decoder.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/manchester_frame_decoder.sv
// rtl/manchester_frame_decoder.sv - Manchester bit/frame recovery: sync hunt, length byte, payload hand-off
module manchester_frame_decoder #(
  parameter logic [7:0] SYNC_WORD = 8'hD5,
  parameter int         MAX_BYTES = 16,
  parameter int         TIMEOUT   = 40
) (
  input  logic       clk,
  input  logic       globalResetN,
  input  logic       manIn,
  input  logic       delayPulse,
  input  logic       dataReady,
  output logic [7:0] dataOut,
  output logic       dataValid,
  output logic [7:0] frameLen,
  output logic       frameStart,
  output logic       frameEnd,
  output logic       frameErr
);
  localparam int                IDLE_W    = $clog2(TIMEOUT + 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);
  localparam logic [IDLE_W-1:0] IDLE_ONE  = IDLE_W'(1);
  localparam logic [7:0]        MAX_LEN   = 8'(MAX_BYTES);

  typedef enum logic [1:0] {HUNT, LEN, DATA} stateT;

  stateT             state, stateNext;
  logic [7:0]        shreg, shregNext, shifted;
  logic [2:0]        bitCnt, bitCntNext;
  logic [7:0]        remain, remainNext;
  logic [IDLE_W-1:0] idleCnt, idleNext;
  logic [7:0]        dataOutNext, frameLenNext;
  logic              dataValidNext, startNext, endNext, errNext;
  logic              goHunt;

  always_ff @(posedge clk or negedge globalResetN) begin
    if (!globalResetN) begin
      state      <= HUNT;
      shreg      <= '0;
      bitCnt     <= '0;
      remain     <= '0;
      idleCnt    <= '0;
      dataOut    <= '0;
      dataValid  <= 1'b0;
      frameLen   <= '0;
      frameStart <= 1'b0;
      frameEnd   <= 1'b0;
      frameErr   <= 1'b0;
    end else begin
      state      <= stateNext;
      shreg      <= shregNext;
      bitCnt     <= bitCntNext;
      remain     <= remainNext;
      idleCnt    <= idleNext;
      dataOut    <= dataOutNext;
      dataValid  <= dataValidNext;
      frameLen   <= frameLenNext;
      frameStart <= startNext;
      frameEnd   <= endNext;
      frameErr   <= errNext;
    end
  end

  always_comb begin
    stateNext     = state;
    shregNext     = shreg;
    bitCntNext    = bitCnt;
    remainNext    = remain;
    idleNext      = idleCnt;
    dataOutNext   = dataOut;
    dataValidNext = dataValid;
    frameLenNext  = frameLen;
    startNext     = 1'b0;
    endNext       = 1'b0;
    errNext       = 1'b0;
    goHunt        = 1'b0;
    shifted       = {shreg[6:0], manIn};

    // A byte loaded below overrides this clear, so a same-cycle handshake is never an overrun.
    if (dataValid && dataReady) dataValidNext = 1'b0;

    case (state)
      HUNT: begin
        idleNext = '0;
        if (delayPulse) begin
          shregNext = shifted;
          if (shifted == SYNC_WORD) begin
            stateNext  = LEN;
            bitCntNext = '0;
            startNext  = 1'b1;
          end
        end
      end
      LEN, DATA: begin
        if (delayPulse) begin
          idleNext   = '0;
          shregNext  = shifted;
          bitCntNext = bitCnt + 3'd1;
          if (bitCnt == 3'd7) begin
            if (state == LEN) begin
              frameLenNext = shifted;
              if (shifted == 8'd0 || shifted > MAX_LEN) begin
                errNext = 1'b1;
                goHunt  = 1'b1;
              end else begin
                remainNext = shifted;
                stateNext  = DATA;
              end
            end else if (dataValid && !dataReady) begin
              errNext = 1'b1;
              goHunt  = 1'b1;
            end else begin
              dataOutNext   = shifted;
              dataValidNext = 1'b1;
              remainNext    = remain - 8'd1;
              if (remain == 8'd1) begin
                endNext = 1'b1;
                goHunt  = 1'b1;
              end
            end
          end
        end else if (idleCnt == IDLE_LAST) begin
          errNext = 1'b1;
          goHunt  = 1'b1;
        end else begin
          idleNext = idleCnt + IDLE_ONE;
        end
      end
      default: goHunt = 1'b1;
    endcase

    if (goHunt) begin
      stateNext  = HUNT;
      shregNext  = '0;
      bitCntNext = '0;
      idleNext   = '0;
    end
  end
endmodule

// File: tb/tb_manchester_frame_decoder.sv
// tb/tb_manchester_frame_decoder.sv - scoreboard bench for manchester_frame_decoder
`timescale 1ns/1ps
module tb_manchester_frame_decoder;
  localparam logic [7:0] SYNC     = 8'hD5;
  localparam int         MAXB     = 16;
  localparam int         TMO      = 40;
  localparam int         CELL     = 16;
  localparam int         PULSE_AT = 12;
  localparam int K_START = 0, K_BYTE = 1, K_END = 2, K_ERR = 3;

  logic       clk = 1'b0;
  logic       globalResetN, manIn, delayPulse, dataReady;
  logic [7:0] dataOut, frameLen;
  logic       dataValid, frameStart, frameEnd, frameErr;

  int tests = 0, fails = 0, cyc = 0, readyMode = 0;
  bit monOn = 1'b0;

  typedef struct {int kind; int val; int at; int flen;} evT;
  evT expQ[$];

  manchester_frame_decoder #(.SYNC_WORD(SYNC), .MAX_BYTES(MAXB), .TIMEOUT(TMO)) dut (
    .clk(clk), .globalResetN(globalResetN), .manIn(manIn), .delayPulse(delayPulse),
    .dataReady(dataReady), .dataOut(dataOut), .dataValid(dataValid), .frameLen(frameLen),
    .frameStart(frameStart), .frameEnd(frameEnd), .frameErr(frameErr)
  );

  always #0.5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: frame-level parse of the decoded bit stream, timeout by cycle distance.
  int         mMode, mNb, mLeft, mLen, mLastP;
  logic [7:0] mHist, mAcc;
  bit         mPend;

  task automatic modelReset();
    mMode = 0; mNb = 0; mLeft = 0; mLen = 0; mLastP = 0;
    mHist = 8'h00; mAcc = 8'h00; mPend = 1'b0;
  endtask

  task automatic pushEv(input int k, input int v, input int at);
    evT e;
    e.kind = k; e.val = v; e.at = at; e.flen = mLen;
    expQ.push_back(e);
  endtask

  task automatic toHunt();
    mMode = 0; mHist = 8'h00;
  endtask

  task automatic modelStep(input int c, input bit p, input logic b, input bit r);
    bit hs, loaded;
    hs = mPend && r;
    loaded = 1'b0;
    if (mMode == 0) begin
      if (p) begin
        mHist = {mHist[6:0], b};
        if (mHist == SYNC) begin
          pushEv(K_START, 0, c + 1);
          mMode = 1; mNb = 0; mLastP = c;
        end
      end
    end else if (p) begin
      mLastP = c;
      mAcc = {mAcc[6:0], b};
      mNb++;
      if (mNb == 8) begin
        mNb = 0;
        if (mMode == 1) begin
          mLen = int'(mAcc);
          if (mLen == 0 || mLen > MAXB) begin
            pushEv(K_ERR, 0, c + 1); toHunt();
          end else begin
            mLeft = mLen; mMode = 2;
          end
        end else if (mPend && !r) begin
          pushEv(K_ERR, 0, c + 1); toHunt();
        end else begin
          pushEv(K_BYTE, int'(mAcc), c + 1);
          loaded = 1'b1;
          mLeft--;
          if (mLeft == 0) begin
            pushEv(K_END, 0, c + 1); toHunt();
          end
        end
      end
    end else if (c - mLastP == TMO) begin
      pushEv(K_ERR, 0, c + 1); toHunt();
    end
    if (loaded) mPend = 1'b1;
    else if (hs) mPend = 1'b0;
  endtask

  function automatic string kname(input int k);
    case (k)
      K_START: return "frameStart";
      K_BYTE:  return "byte";
      K_END:   return "frameEnd";
      default: return "frameErr";
    endcase
  endfunction

  task automatic check(input int k, input int v);
    evT e;
    tests++;
    if (expQ.size() == 0) begin
      fails++;
      $display("FAIL unexpected %s at cycle %0d (value %0h), expected no event", kname(k), cyc, v);
    end else begin
      e = expQ.pop_front();
      if (e.kind != k || (k == K_BYTE && e.val != v) || e.at != cyc || e.flen != int'(frameLen)) begin
        fails++;
        $display("FAIL %s event: got %s val=%0h cycle=%0d frameLen=%0d, expected %s val=%0h cycle=%0d frameLen=%0d",
                 kname(e.kind), kname(k), v, cyc, frameLen, kname(e.kind), e.val, e.at, e.flen);
      end
    end
  endtask

  task automatic expectEq(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Monitor: turns DUT outputs into events and pops the scoreboard.
  logic       pV = 1'b0, pR = 1'b0;
  logic [7:0] pD = 8'h00;
  always @(negedge clk) begin
    if (!monOn) begin
      pV = 1'b0; pR = 1'b0; pD = 8'h00;
    end else begin
      if (frameStart) check(K_START, 0);
      if (dataValid && (!pV || pR)) check(K_BYTE, int'(dataOut));
      if (frameEnd) check(K_END, 0);
      if (frameErr) check(K_ERR, 0);
      if (pV && !pR) begin
        tests++;
        if (!dataValid || dataOut !== pD) begin
          fails++;
          $display("FAIL held byte: got valid=%0b data=%0h, expected valid=1 data=%0h", dataValid, dataOut, pD);
        end
      end
      pV = dataValid; pR = dataReady; pD = dataOut;
    end
  end

  function automatic bit policyReady();
    case (readyMode)
      0:       return 1'b1;
      1:       return 1'b0;
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  task automatic drv(input logic m, input bit p, input bit r);
    @(posedge clk);
    #0.1;
    manIn = m; delayPulse = p; dataReady = r;
    modelStep(cyc, p, m, r);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drv(1'b0, 1'b0, policyReady());
  endtask

  task automatic sendBit(input logic b, input bit forceReady);
    for (int k = 0; k < CELL; k++)
      drv((k < CELL / 2) ? ~b : b, k == PULSE_AT, (forceReady && k == PULSE_AT) ? 1'b1 : policyReady());
  endtask

  task automatic sendByte(input logic [7:0] v, input bit lastReady);
    for (int i = 7; i >= 0; i--) sendBit(v[i], lastReady && i == 0);
  endtask

  task automatic checkAllZero(input string tag);
    expectEq({tag, " dataOut"}, int'(dataOut), 0);
    expectEq({tag, " dataValid"}, int'(dataValid), 0);
    expectEq({tag, " frameLen"}, int'(frameLen), 0);
    expectEq({tag, " frameStart"}, int'(frameStart), 0);
    expectEq({tag, " frameEnd"}, int'(frameEnd), 0);
    expectEq({tag, " frameErr"}, int'(frameErr), 0);
  endtask

  initial begin
    globalResetN = 1'b0; manIn = 1'b0; delayPulse = 1'b0; dataReady = 1'b0;
    modelReset();
    repeat (3) @(posedge clk);
    #0.2;
    checkAllZero("reset");
    @(posedge clk);
    #0.1;
    globalResetN = 1'b1;
    monOn = 1'b1;

    // Clean frame
    readyMode = 0;
    idle(20);
    sendByte(8'h55, 0); sendByte(8'h55, 0); sendByte(SYNC, 0); sendByte(8'h03, 0);
    sendByte(8'hA1, 0); sendByte(8'hB2, 0); sendByte(8'hC3, 0);
    idle(40);

    // Bad lengths, then a good frame
    sendByte(SYNC, 0); sendByte(8'h00, 0); idle(20);
    sendByte(SYNC, 0); sendByte(8'h11, 0); idle(20);
    sendByte(SYNC, 0); sendByte(8'h02, 0); sendByte(8'h5A, 0); sendByte(8'h3C, 0);
    idle(40);

    // Overrun with consumer stalled
    readyMode = 1;
    sendByte(SYNC, 0); sendByte(8'h02, 0); sendByte(8'h11, 0); sendByte(8'h22, 0);
    idle(20);
    expectEq("overrun held valid", int'(dataValid), 1);
    expectEq("overrun held data", int'(dataOut), 8'h11);
    readyMode = 0;
    idle(5);
    expectEq("overrun drained", int'(dataValid), 0);

    // Handshake in the exact cycle byte 2 completes
    readyMode = 1;
    sendByte(SYNC, 0); sendByte(8'h02, 0); sendByte(8'h77, 0); sendByte(8'h88, 1);
    idle(10);
    expectEq("simul hs valid", int'(dataValid), 1);
    expectEq("simul hs data", int'(dataOut), 8'h88);
    readyMode = 0;
    idle(5);

    // Timeout after 4 payload bits, then a long idle in HUNT
    sendByte(SYNC, 0); sendByte(8'h03, 0);
    sendBit(1'b1, 0); sendBit(1'b0, 0); sendBit(1'b1, 0); sendBit(1'b0, 0);
    idle(TMO + 20);
    idle(200);

    // Asynchronous reset mid-frame
    readyMode = 1;
    sendByte(SYNC, 0); sendByte(8'h03, 0); sendByte(8'hA1, 0);
    sendBit(1'b1, 0); sendBit(1'b0, 0); sendBit(1'b1, 0);
    @(posedge clk);
    #0.2;
    monOn = 1'b0;
    globalResetN = 1'b0;
    #0.1;
    checkAllZero("async reset");
    expectEq("events pending at reset", expQ.size(), 0);
    expQ.delete();
    modelReset();
    delayPulse = 1'b0;
    repeat (3) @(posedge clk);
    #0.1;
    globalResetN = 1'b1;
    monOn = 1'b1;
    readyMode = 0;
    sendByte(8'h03, 0);
    idle(60);

    // Randomized frames
    for (int f = 0; f < 12; f++) begin
      int len;
      readyMode = ($urandom_range(0, 1) == 1) ? 2 : 0;
      if ($urandom_range(0, 1) == 1) sendByte(8'($urandom), 0);
      sendByte(SYNC, 0);
      len = int'($urandom_range(0, 18));
      sendByte(8'(len), 0);
      for (int i = 0; i < len && i < MAXB; i++) sendByte(8'($urandom), 0);
      idle(int'($urandom_range(0, 60)));
    end

    readyMode = 0;
    idle(300);
    expectEq("scoreboard drained", expQ.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
